button_pulse_array: RTL and testbench
=====================================

// Module: button_pulse_array
// PURPOSE
//  Parametrised N-channel user-input conditioner for active-low push-buttons (KEY pins).
//  Each channel is synchronised, debounced and converted to a one-cycle press pulse, a
//  one-cycle release pulse and a clean held level. Sits between board keys and game FSMs.
// PARAMETERS
//  N               2   number of independent button channels (>=1)
//  SYNC_STAGES     2   synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES 4   consecutive stable samples needed to change debounced state (>=1)
//  REPEAT_DELAY    8   cycles from first press pulse to first repeat pulse (>=1, repeat only)
//  REPEAT_PERIOD   4   cycles between subsequent repeat pulses (>=1, repeat only)
// PORTS
//  clk    in   1  system clock; all state on posedge
//  reset  in   1  asynchronous, active-low reset (0 = reset asserted)
//  in     in   N  raw button inputs, active-low (0 = pressed), asynchronous to clk
//  out    out  N  press pulse: 1 for exactly one cycle per accepted press (plus repeats)
//  rel    out  N  release pulse: 1 for exactly one cycle per accepted release
//  held   out  N  debounced level, active-high (1 = pressed)
// BEHAVIOUR
//  Reset (reset==0, async): out=0, rel=0, held=0, sync flops=1 (released), counters=0.
//   Takes effect immediately, mid-press or mid-debounce; no pulse emitted on reset entry.
//   After reset deasserts with a key still low, a press is reported after full latency.
//  Per channel, fully independent; simultaneous events on channels give simultaneous pulses.
//  Synchroniser: SYNC_STAGES-deep shift chain; s = last stage, inverted (s=1 means pressed).
//  Debounce, states RELEASED (held=0) / PRESSED (held=1), counter cnt width clog2(DEBOUNCE_CYCLES+1):
//   - s == held: cnt <= 0.
//   - s != held and cnt <  DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - s != held and cnt == DEBOUNCE_CYCLES-1: held <= s, cnt <= 0.
//   - DEBOUNCE_CYCLES==1: held follows s with one cycle delay (no filtering).
//   - Glitch shorter than DEBOUNCE_CYCLES cycles at s: ignored, no pulse, cnt restarts.
//  Pulses are registered, updated on the same edge as held:
//   out <= (held 0->1) ; rel <= (held 1->0); never both 1 on one channel in one cycle.
//  Latency: in sampled low at edge 1 -> held and out rise at edge SYNC_STAGES+DEBOUNCE_CYCLES
//   (6 with defaults). Release latency identical.
//  Holding the key produces exactly one out pulse (repeat feature disabled).
//  Minimum out spacing on one channel: 2*DEBOUNCE_CYCLES cycles.
// CONFIGURATION
//  Macro BUTTON_PULSE_REPEAT_EN:
//   Defined: per-channel repeat counter. Press pulse at edge P; while held stays 1, extra out
//    pulses at P+REPEAT_DELAY, then every REPEAT_PERIOD cycles. Release (held 1->0) or reset
//    clears the counter at once; no repeat pulse coincides with a rel pulse.
//   Undefined: no repeat logic synthesised; REPEAT_* parameters accepted but ignored; one
//    out pulse per press.
// TESTING
//  1 Reset: reset=0 with in=2'b00 -> out=0, rel=0, held=0 throughout; release reset, hold
//    in=2'b00 -> out=2'b11 one cycle at 6th edge, held=2'b11.
//  2 Single press ch0: in[0] low 20 cycles then high -> one out[0] pulse at edge 6,
//    one rel[0] pulse 6 edges after release, held[0] high in between; ch1 silent.
//  3 Glitch: in[0] low for 3 cycles (DEBOUNCE_CYCLES=4) -> no out, held stays 0;
//    low for 4 cycles -> exactly one out pulse.
//  4 Reset mid-operation: assert reset while held[1]=1 -> held, out, rel 0 in same cycle
//    (async), no rel pulse afterwards.
//  5 Parametrisation: N=4, DEBOUNCE_CYCLES=1 -> press on ch3 gives out[3] at edge 3;
//    simultaneous press ch0+ch2 -> out=4'b0101 single cycle.
//  6 BUTTON_PULSE_REPEAT_EN defined, in[0] held 30 cycles -> out[0] at P, P+8, P+12, P+16,
//    ...; stops on release; undefined -> only pulse at P.

Source files
------------

// File: rtl/button_pulse_array.sv
// N-channel active-low push-button conditioner: synchroniser, debouncer, press/release pulses and held level.
// Optional auto-repeat of press pulses while held is enabled by defining BUTTON_PULSE_REPEAT_EN.
module button_pulse_array #(
  parameter int N               = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rel,
  output logic [N-1:0] held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_PULSE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER = RW'(REPEAT_PERIOD);
`endif

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   held_q, held_d;
    logic                   out_q, out_d;
    logic                   rel_q, rel_d;
    logic                   s;
    logic                   rpt_hit;

    // Sync chain resets to the released level so reset exit never looks like a press.
    assign s = ~sync_q[SYNC_STAGES-1];

    always_comb begin
      held_d = held_q;
      cnt_d  = '0;
      if (s != held_q) begin
        if (cnt_q == CNT_LAST) held_d = s;
        else                   cnt_d  = cnt_q + 1'b1;
      end
      out_d = (~held_q & held_d) | rpt_hit;
      rel_d = held_q & ~held_d;
    end

`ifdef BUTTON_PULSE_REPEAT_EN
    logic [RW-1:0] rpt_q, rpt_d;
    logic          per_q, per_d;

    // rpt_q counts edges since the last press/repeat pulse; per_q selects delay vs period.
    always_comb begin
      rpt_d   = '0;
      per_d   = 1'b0;
      rpt_hit = 1'b0;
      if (held_q & held_d) begin
        if (rpt_q == (per_q ? R_PER : R_DLY)) begin
          rpt_hit = 1'b1;
          rpt_d   = RW'(1);
          per_d   = 1'b1;
        end else begin
          rpt_d = rpt_q + 1'b1;
          per_d = per_q;
        end
      end else if (~held_q & held_d) begin
        rpt_d = RW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rpt_q <= '0;
        per_q <= 1'b0;
      end else begin
        rpt_q <= rpt_d;
        per_q <= per_d;
      end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '1;
        cnt_q  <= '0;
        held_q <= 1'b0;
        out_q  <= 1'b0;
        rel_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[g]};
        cnt_q  <= cnt_d;
        held_q <= held_d;
        out_q  <= out_d;
        rel_q  <= rel_d;
      end
    end

    assign out[g]  = out_q;
    assign rel[g]  = rel_q;
    assign held[g] = held_q;
  end

endmodule

// File: tb/tb_button_pulse_array.sv
// Bench for button_pulse_array: vector table plus scoreboard of expected pulse cycles,
// with hand-written sequences for reset and a 4-channel no-filter instance.
module tb_button_pulse_array;

  localparam int RD = 8;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [1:0] out, rel, held;
  logic [3:0] btn4 = 4'hF;
  logic [3:0] out4, rel4, held4;

  button_pulse_array u_dut (
    .clk(clk), .reset(reset), .in(btn), .out(out), .rel(rel), .held(held)
  );

  button_pulse_array #(.N(4), .DEBOUNCE_CYCLES(1)) u_dut4 (
    .clk(clk), .reset(reset), .in(btn4), .out(out4), .rel(rel4), .held(held4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         c;
    logic [1:0] o;
    logic [1:0] r;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] mask;
    int         len;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [1:0] o, input logic [1:0] r);
    exp_t e;
    e.c = c; e.o = o; e.r = r;
    sb.push_back(e);
  endtask

  // Every nonzero out/rel cycle on the 2-channel DUT must match the next scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out !== 2'b00 || rel !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {28'd0, out, rel}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.c);
        check("pulse_out", {30'd0, out}, {30'd0, e.o});
        check("pulse_rel", {30'd0, rel}, {30'd0, e.r});
      end
    end
  end

  task automatic run_vec(input logic [1:0] mask, input int len);
    int e1, t;
    @(negedge clk);
    btn = ~mask;
    e1 = cyc + 1;
    if (len >= 4) begin
      push(e1 + 5, mask, 2'b00);
`ifdef BUTTON_PULSE_REPEAT_EN
      t = e1 + 5 + RD;
      while (t <= e1 + len + 4) begin
        push(t, mask, 2'b00);
        t += RP;
      end
`endif
      push(e1 + len + 5, 2'b00, mask);
    end
    repeat (len) @(negedge clk);
    if (len >= 6) check("held_during_press", {30'd0, held}, {30'd0, mask});
    btn = 2'b11;
    repeat (14) @(negedge clk);
    check("held_after_release", {30'd0, held}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int e1;
    vecs[0] = '{2'b01, 20};
    vecs[1] = '{2'b01, 3};
    vecs[2] = '{2'b01, 4};
    vecs[3] = '{2'b10, 10};
    vecs[4] = '{2'b11, 8};
    vecs[5] = '{2'b01, 30};
    vecs[6] = '{2'b10, 2};
    vecs[7] = '{2'b11, 5};

    // Reset held with both keys pressed: outputs stay quiet.
    repeat (6) begin
      @(negedge clk);
      check("reset_outputs", {26'd0, out, rel, held}, 32'd0);
    end
    reset = 1'b1;
    e1 = cyc + 1;
    push(e1 + 5, 2'b11, 2'b00);
    repeat (4) @(negedge clk);
    check("held_before_latency", {30'd0, held}, 32'd0);
    repeat (3) @(negedge clk);
    check("held_after_reset_exit", {30'd0, held}, 32'd3);
    btn = 2'b11;
    push(cyc + 1 + 5, 2'b00, 2'b11);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i].mask, vecs[i].len);

    // Asynchronous reset while ch1 is held: immediate clear, no release pulse afterwards.
    @(negedge clk);
    btn = 2'b01;
    e1 = cyc + 1;
    push(e1 + 5, 2'b10, 2'b00);
    repeat (10) @(negedge clk);
    check("held_before_reset", {30'd0, held}, 32'd2);
    reset = 1'b0;
    #1;
    check("async_reset_held", {30'd0, held}, 32'd0);
    check("async_reset_pulses", {30'd0, out | rel}, 32'd0);
    repeat (3) @(negedge clk);
    btn = 2'b11;
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("held_after_mid_reset", {30'd0, held}, 32'd0);

    // Four channels, no debounce filtering: latency is 3 edges.
    btn4 = 4'b0111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("n4_out_early", {28'd0, out4}, 32'd0);
    @(posedge clk); #1;
    check("n4_out_ch3", {28'd0, out4}, 32'h8);
    check("n4_held_ch3", {28'd0, held4}, 32'h8);
    @(posedge clk); #1;
    check("n4_out_single", {28'd0, out4}, 32'd0);
    @(negedge clk);
    btn4 = 4'hF;
    repeat (6) @(negedge clk);
    check("n4_held_released", {28'd0, held4}, 32'd0);
    btn4 = 4'b1010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("n4_out_simul", {28'd0, out4}, 32'h5);
    @(posedge clk); #1;
    check("n4_out_simul_single", {28'd0, out4}, 32'd0);
    @(negedge clk);
    btn4 = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("n4_rel_simul", {28'd0, rel4}, 32'h5);
    @(posedge clk); #1;
    check("n4_rel_single", {28'd0, rel4}, 32'd0);
    repeat (4) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
